// File: rtl/initializer_pkg.sv
// Shared types and constants for the AHB configuration initializer.
// INIT_TAG_CHECK_EN (see init_word_decode) enables tag checking on fetched words.
package initializer_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR1,
    ST_DATA1,
    ST_ADDR2,
    ST_DATA2,
    ST_ADDR3,
    ST_DATA3,
    ST_ADDR4,
    ST_DATA4,
    ST_ADDR5,
    ST_DATA5,
    ST_KICKSTART,
    ST_DONE
  } state_e;

  localparam logic [2:0] TAG_WIDTH  = 3'b001;
  localparam logic [2:0] TAG_HEIGHT = 3'b010;
  localparam logic [2:0] TAG_RDADDR = 3'b011;
  localparam logic [2:0] TAG_WRADDR = 3'b100;
  localparam logic [2:0] TAG_FILTER = 3'b101;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [1:0] HRESP_OKAY    = 2'b00;

  localparam int unsigned LAST_WORD = 4;

  // Word index (0..4) handled by an address/data state pair.
  function automatic logic [2:0] word_index(state_e s);
    case (s)
      ST_ADDR1, ST_DATA1: return 3'd0;
      ST_ADDR2, ST_DATA2: return 3'd1;
      ST_ADDR3, ST_DATA3: return 3'd2;
      ST_ADDR4, ST_DATA4: return 3'd3;
      ST_ADDR5, ST_DATA5: return 3'd4;
      default:            return 3'd0;
    endcase
  endfunction

  function automatic state_e addr_state(logic [2:0] idx);
    case (idx)
      3'd0:    return ST_ADDR1;
      3'd1:    return ST_ADDR2;
      3'd2:    return ST_ADDR3;
      3'd3:    return ST_ADDR4;
      default: return ST_ADDR5;
    endcase
  endfunction

  function automatic state_e data_state(logic [2:0] idx);
    case (idx)
      3'd0:    return ST_DATA1;
      3'd1:    return ST_DATA2;
      3'd2:    return ST_DATA3;
      3'd3:    return ST_DATA4;
      default: return ST_DATA5;
    endcase
  endfunction

  function automatic logic [2:0] expected_tag(logic [2:0] idx);
    case (idx)
      3'd0:    return TAG_WIDTH;
      3'd1:    return TAG_HEIGHT;
      3'd2:    return TAG_RDADDR;
      3'd3:    return TAG_WRADDR;
      default: return TAG_FILTER;
    endcase
  endfunction

  function automatic logic is_addr_state(state_e s);
    return (s == ST_ADDR1) || (s == ST_ADDR2) || (s == ST_ADDR3) ||
           (s == ST_ADDR4) || (s == ST_ADDR5);
  endfunction

  function automatic logic is_data_state(state_e s);
    return (s == ST_DATA1) || (s == ST_DATA2) || (s == ST_DATA3) ||
           (s == ST_DATA4) || (s == ST_DATA5);
  endfunction

endpackage

// File: rtl/init_word_decode.sv
// Splits a fetched configuration word into tag-check result and 29-bit value.
// INIT_TAG_CHECK_EN defined: tag must match the word slot being fetched.
// INIT_TAG_CHECK_EN undefined: tag bits are ignored, slot order decides the field.
module init_word_decode
  import initializer_pkg::*;
#(
  parameter int unsigned BUSWIDTH = 32
) (
  input  logic [BUSWIDTH-1:0] hrdata_i,
  input  logic [2:0]          idx_i,
  output logic                tag_ok_o,
  output logic [28:0]         value_o
);

  assign value_o = hrdata_i[28:0];

`ifdef INIT_TAG_CHECK_EN
  assign tag_ok_o = (hrdata_i[31:29] == expected_tag(idx_i));
`else
  logic unused_tag;
  assign unused_tag = ^{hrdata_i[BUSWIDTH-1:29], idx_i};
  assign tag_ok_o   = 1'b1;
`endif

endmodule

// File: rtl/ahb_initializer.sv
// One-shot AHB-Lite read master: fetches five configuration words from
// CFG_ADDR, decodes them into filter-engine settings, then raises final_enable.
// Build option INIT_TAG_CHECK_EN: reject and reread words whose tag does not
// match the slot being fetched.
// State table:
//   IDLE      | one cycle after reset release
//   ADDRn     | request bus, issue NONSEQ read when granted and ready
//   DATAn     | wait for hready, latch field n or retry on error/bad tag
//   KICKSTART | configuration complete, raise final_enable, drop request
//   DONE      | terminal, hold everything until reset
module ahb_initializer
  import initializer_pkg::*;
#(
  parameter int unsigned           BUSWIDTH = 32,
  parameter logic [BUSWIDTH-1:0]   CFG_ADDR = 32'h0000_0D09
) (
  input  logic                ahb_hclk,
  input  logic                n_rst,
  output logic [1:0]          ahb_htrans,
  output logic [2:0]          ahb_hburst,
  output logic                ahb_hwrite,
  output logic                ahb_hprot,
  output logic [BUSWIDTH-1:0] ahb_haddr,
  output logic [BUSWIDTH-1:0] ahb_hwdata,
  input  logic [BUSWIDTH-1:0] ahb_hrdata,
  input  logic                ahb_hgrant,
  output logic                ahb_hlock,
  output logic                ahb_hbusreq,
  input  logic                ahb_hready,
  input  logic [1:0]          ahb_hresp,
  output logic [BUSWIDTH-1:0] width,
  output logic [BUSWIDTH-1:0] height,
  output logic [BUSWIDTH-1:0] readStartAddress,
  output logic [BUSWIDTH-1:0] writeStartAddress,
  output logic                filterType,
  output logic                final_enable
);

  state_e              state_q, state_d;
  logic [1:0]          htrans_q, htrans_d;
  logic [BUSWIDTH-1:0] haddr_q, haddr_d;
  logic                hbusreq_q, hbusreq_d;
  logic [BUSWIDTH-1:0] width_q, width_d;
  logic [BUSWIDTH-1:0] height_q, height_d;
  logic [BUSWIDTH-1:0] rdaddr_q, rdaddr_d;
  logic [BUSWIDTH-1:0] wraddr_q, wraddr_d;
  logic                filter_q, filter_d;
  logic                final_en_q, final_en_d;

  logic [2:0]          idx;
  logic                tag_ok;
  logic [28:0]         value;
  logic [BUSWIDTH-1:0] value_ext;

  assign idx       = word_index(state_q);
  assign value_ext = {{(BUSWIDTH-29){1'b0}}, value};

  init_word_decode #(
    .BUSWIDTH (BUSWIDTH)
  ) u_decode (
    .hrdata_i (ahb_hrdata),
    .idx_i    (idx),
    .tag_ok_o (tag_ok),
    .value_o  (value)
  );

  // Next state, bus controls and field latching.
  always_comb begin
    state_d    = state_q;
    htrans_d   = HTRANS_IDLE;
    haddr_d    = '0;
    width_d    = width_q;
    height_d   = height_q;
    rdaddr_d   = rdaddr_q;
    wraddr_d   = wraddr_q;
    filter_d   = filter_q;
    final_en_d = final_en_q;

    if (state_q == ST_IDLE) begin
      state_d = ST_ADDR1;
    end else if (is_addr_state(state_q)) begin
      if (ahb_hgrant && ahb_hready) begin
        htrans_d = HTRANS_NONSEQ;
        haddr_d  = CFG_ADDR;
        state_d  = data_state(idx);
      end
    end else if (is_data_state(state_q)) begin
      if (ahb_hready) begin
        if (ahb_hresp != HRESP_OKAY || !tag_ok) begin
          state_d = addr_state(idx);
        end else begin
          case (idx)
            3'd0:    width_d  = value_ext;
            3'd1:    height_d = value_ext;
            3'd2:    rdaddr_d = value_ext;
            3'd3:    wraddr_d = value_ext;
            default: filter_d = value[0];
          endcase
          state_d = (idx == 3'(LAST_WORD)) ? ST_KICKSTART : addr_state(idx + 3'd1);
        end
      end
    end else if (state_q == ST_KICKSTART) begin
      final_en_d = 1'b1;
      state_d    = ST_DONE;
    end

    // Bus request tracks the state being entered so it is valid for the
    // whole ADDRn/DATAn window and drops together with KICKSTART.
    hbusreq_d = is_addr_state(state_d) || is_data_state(state_d);
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge ahb_hclk) begin
    if (n_rst) begin
      state_q    <= ST_IDLE;
      htrans_q   <= HTRANS_IDLE;
      haddr_q    <= '0;
      hbusreq_q  <= 1'b0;
      width_q    <= '0;
      height_q   <= '0;
      rdaddr_q   <= '0;
      wraddr_q   <= '0;
      filter_q   <= 1'b0;
      final_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      htrans_q   <= htrans_d;
      haddr_q    <= haddr_d;
      hbusreq_q  <= hbusreq_d;
      width_q    <= width_d;
      height_q   <= height_d;
      rdaddr_q   <= rdaddr_d;
      wraddr_q   <= wraddr_d;
      filter_q   <= filter_d;
      final_en_q <= final_en_d;
    end
  end

  assign ahb_htrans        = htrans_q;
  assign ahb_haddr         = haddr_q;
  assign ahb_hbusreq       = hbusreq_q;
  assign ahb_hburst        = HBURST_SINGLE;
  assign ahb_hwrite        = 1'b0;
  assign ahb_hprot         = 1'b1;
  assign ahb_hlock         = 1'b0;
  assign ahb_hwdata        = '0;
  assign width             = width_q;
  assign height            = height_q;
  assign readStartAddress  = rdaddr_q;
  assign writeStartAddress = wraddr_q;
  assign filterType        = filter_q;
  assign final_enable      = final_en_q;

endmodule

// File: tb/tb_ahb_initializer.sv
// Directed bench for ahb_initializer. Honours INIT_TAG_CHECK_EN for the
// tag-mismatch step.
module tb_ahb_initializer;

  logic        ahb_hclk = 1'b0;
  logic        n_rst;
  logic [1:0]  ahb_htrans;
  logic [2:0]  ahb_hburst;
  logic        ahb_hwrite;
  logic        ahb_hprot;
  logic [31:0] ahb_haddr;
  logic [31:0] ahb_hwdata;
  logic [31:0] ahb_hrdata;
  logic        ahb_hgrant;
  logic        ahb_hlock;
  logic        ahb_hbusreq;
  logic        ahb_hready;
  logic [1:0]  ahb_hresp;
  logic [31:0] width;
  logic [31:0] height;
  logic [31:0] readStartAddress;
  logic [31:0] writeStartAddress;
  logic        filterType;
  logic        final_enable;

  int n_cmp = 0;
  int n_mis = 0;

  logic [31:0] words [5] = '{32'h20000151, 32'h40000151, 32'h600001F4,
                             32'h8000157C, 32'hA0000001};
  logic [31:0] expv  [5] = '{32'h151, 32'h151, 32'h1F4, 32'h157C, 32'h1};

  ahb_initializer dut (
    .ahb_hclk          (ahb_hclk),
    .n_rst             (n_rst),
    .ahb_htrans        (ahb_htrans),
    .ahb_hburst        (ahb_hburst),
    .ahb_hwrite        (ahb_hwrite),
    .ahb_hprot         (ahb_hprot),
    .ahb_haddr         (ahb_haddr),
    .ahb_hwdata        (ahb_hwdata),
    .ahb_hrdata        (ahb_hrdata),
    .ahb_hgrant        (ahb_hgrant),
    .ahb_hlock         (ahb_hlock),
    .ahb_hbusreq       (ahb_hbusreq),
    .ahb_hready        (ahb_hready),
    .ahb_hresp         (ahb_hresp),
    .width             (width),
    .height            (height),
    .readStartAddress  (readStartAddress),
    .writeStartAddress (writeStartAddress),
    .filterType        (filterType),
    .final_enable      (final_enable)
  );

  always #5 ahb_hclk = ~ahb_hclk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge ahb_hclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] field(input int idx);
    case (idx)
      0:       return width;
      1:       return height;
      2:       return readStartAddress;
      3:       return writeStartAddress;
      default: return 32'(filterType);
    endcase
  endfunction

  task automatic do_reset();
    n_rst      = 1'b1;
    ahb_hgrant = 1'b1;
    ahb_hready = 1'b1;
    ahb_hresp  = 2'b00;
    ahb_hrdata = 32'h0;
    step();
    step();
    n_rst = 1'b0;
  endtask

  // One address edge then one data edge for word idx, all signals friendly.
  task automatic read_word(input int idx);
    ahb_hrdata = words[idx];
    step();
    chk("addr_htrans", 32'(ahb_htrans), 32'h2);
    chk("addr_haddr", ahb_haddr, 32'h0D09);
    step();
    chk($sformatf("field%0d", idx), field(idx), expv[idx]);
    chk("data_htrans", 32'(ahb_htrans), 32'h0);
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_width"}, width, 32'h0);
    chk({tag, "_height"}, height, 32'h0);
    chk({tag, "_rd"}, readStartAddress, 32'h0);
    chk({tag, "_wr"}, writeStartAddress, 32'h0);
    chk({tag, "_filt"}, 32'(filterType), 32'h0);
    chk({tag, "_final"}, 32'(final_enable), 32'h0);
    chk({tag, "_htrans"}, 32'(ahb_htrans), 32'h0);
    chk({tag, "_haddr"}, ahb_haddr, 32'h0);
    chk({tag, "_busreq"}, 32'(ahb_hbusreq), 32'h0);
  endtask

  initial begin
    n_rst      = 1'b1;
    ahb_hgrant = 1'b1;
    ahb_hready = 1'b1;
    ahb_hresp  = 2'b00;
    ahb_hrdata = 32'h0;

    // Normal run: final_enable on edge 12 after release.
    do_reset();
    chk_cleared("rst");
    chk("hburst", 32'(ahb_hburst), 32'h0);
    chk("hwrite", 32'(ahb_hwrite), 32'h0);
    chk("hprot", 32'(ahb_hprot), 32'h1);
    chk("hlock", 32'(ahb_hlock), 32'h0);
    chk("hwdata", ahb_hwdata, 32'h0);
    step();
    chk("n_busreq1", 32'(ahb_hbusreq), 32'h1);
    chk("n_htrans1", 32'(ahb_htrans), 32'h0);
    for (int i = 0; i < 5; i++) read_word(i);
    chk("n_final_e11", 32'(final_enable), 32'h0);
    chk("n_busreq_kick", 32'(ahb_hbusreq), 32'h0);
    step();
    chk("n_final_e12", 32'(final_enable), 32'h1);
    step(); step(); step();
    chk("n_final_hold", 32'(final_enable), 32'h1);
    chk("n_width_hold", width, 32'h151);
    chk("n_filt_hold", 32'(filterType), 32'h1);
    chk("n_busreq_done", 32'(ahb_hbusreq), 32'h0);
    chk("n_hburst_done", 32'(ahb_hburst), 32'h0);

    // Grant withheld for 5 cycles: completion on edge 17.
    do_reset();
    ahb_hgrant = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("g_htrans", 32'(ahb_htrans), 32'h0);
      chk("g_busreq", 32'(ahb_hbusreq), 32'h1);
    end
    ahb_hgrant = 1'b1;
    for (int i = 0; i < 5; i++) read_word(i);
    chk("g_final_e16", 32'(final_enable), 32'h0);
    step();
    chk("g_final_e17", 32'(final_enable), 32'h1);

    // hready low for 3 cycles in DATA2.
    do_reset();
    step();
    read_word(0);
    ahb_hrdata = words[1];
    step();
    chk("w_htrans_issue", 32'(ahb_htrans), 32'h2);
    ahb_hready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("w_height_wait", height, 32'h0);
      chk("w_busreq_wait", 32'(ahb_hbusreq), 32'h1);
    end
    ahb_hready = 1'b1;
    step();
    chk("w_height_latched", height, 32'h151);
    for (int i = 2; i < 5; i++) read_word(i);
    step();
    chk("w_final", 32'(final_enable), 32'h1);

    // Error response in DATA3: discard, reissue ADDR3.
    do_reset();
    step();
    read_word(0);
    read_word(1);
    ahb_hrdata = 32'h600003FF;
    step();
    ahb_hresp = 2'b01;
    step();
    chk("e_rd_unchanged", readStartAddress, 32'h0);
    ahb_hresp  = 2'b00;
    ahb_hrdata = words[2];
    step();
    chk("e_reissue_htrans", 32'(ahb_htrans), 32'h2);
    chk("e_reissue_haddr", ahb_haddr, 32'h0D09);
    step();
    chk("e_rd_latched", readStartAddress, 32'h1F4);
    read_word(3);
    read_word(4);
    step();
    chk("e_final", 32'(final_enable), 32'h1);

    // Wrong tag (height word) returned in DATA1.
    do_reset();
    step();
    ahb_hrdata = words[1];
    step();
    step();
`ifdef INIT_TAG_CHECK_EN
    chk("t_width_reject", width, 32'h0);
    ahb_hrdata = words[0];
    step();
    chk("t_retry_htrans", 32'(ahb_htrans), 32'h2);
    step();
    chk("t_width_retry", width, 32'h151);
`else
    chk("t_width_accept", width, 32'h151);
    chk("t_height_untouched", height, 32'h0);
`endif

    // Reset in DATA4, then full reread.
    do_reset();
    step();
    for (int i = 0; i < 3; i++) read_word(i);
    ahb_hrdata = words[3];
    step();
    n_rst = 1'b1;
    step();
    chk_cleared("mid");
    n_rst = 1'b0;
    step();
    chk("r_busreq1", 32'(ahb_hbusreq), 32'h1);
    for (int i = 0; i < 5; i++) read_word(i);
    chk("r_final_e11", 32'(final_enable), 32'h0);
    step();
    chk("r_final_e12", 32'(final_enable), 32'h1);
    chk("r_wr", writeStartAddress, 32'h157C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
